// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle: requester handshakes on one side, register-file write port on the other.
// The arbiter attaches through the slave modport; the requester/regfile side uses master.
interface wb_port_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               hold;
    logic               flush;
    logic               wen;
    logic [AW-1:0]      waddr;
    logic [DW-1:0]      wdata;
    logic [NREQ-1:0]    grant;

    modport slave (
        input  req_valid, req_addr, req_data, hold, flush,
        output req_ready, wen, waddr, wdata, grant
    );

    modport master (
        output req_valid, req_addr, req_data, hold, flush,
        input  req_ready, wen, waddr, wdata, grant
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ writeback sources,
// with a one-deep registered output stage, x0 write suppression, hold and flush.
module wb_port_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic            wen_reg, wen_next;
    logic [AW-1:0]   waddr_reg, waddr_next;
    logic [DW-1:0]   wdata_reg, wdata_next;
    logic [NREQ-1:0] grant_reg, grant_next;

    logic [PW-1:0]   cand_idx [NREQ];
    logic [NREQ-1:0] cand_valid;
    logic [NREQ-1:0] ready_vec;
    logic [NREQ-1:0] sel_onehot;
    logic [PW-1:0]   sel;
    logic            found;
    logic            accept;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    // Candidate k is requester (rr_ptr + k) mod NREQ; rr_ptr never exceeds NREQ-1.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [PW:0] sum;
            assign sum            = {1'b0, rr_ptr_reg} + (PW+1)'(gi);
            assign cand_idx[gi]   = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
            assign cand_valid[gi] = bus.req_valid[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                found = 1'b1;
                sel   = cand_idx[k];
            end
        end
    end

    // Ready stays low throughout reset even though it is purely combinational.
    assign accept = rst & found & ~bus.hold & ~bus.flush;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign sel_onehot[gi] = (sel == PW'(gi));
            assign ready_vec[gi]  = accept & sel_onehot[gi];
        end
    endgenerate

    assign bus.req_ready = ready_vec;
    assign sel_addr      = bus.req_addr[int'(sel)*AW +: AW];
    assign sel_data      = bus.req_data[int'(sel)*DW +: DW];

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        wen_next    = wen_reg;
        waddr_next  = waddr_reg;
        wdata_next  = wdata_reg;
        grant_next  = grant_reg;
        if (bus.flush) begin
            wen_next = 1'b0;
        end else if (bus.hold) begin
            wen_next = wen_reg;
        end else if (accept) begin
            // x0 writes still complete the handshake but never reach the register file.
            wen_next    = (sel_addr != '0);
            waddr_next  = sel_addr;
            wdata_next  = sel_data;
            grant_next  = sel_onehot;
            rr_ptr_next = (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
        end else begin
            wen_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_reg <= '0;
            wen_reg    <= 1'b0;
            waddr_reg  <= '0;
            wdata_reg  <= '0;
            grant_reg  <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            wen_reg    <= wen_next;
            waddr_reg  <= waddr_next;
            wdata_reg  <= wdata_next;
            grant_reg  <= grant_next;
        end
    end

    assign bus.wen   = wen_reg;
    assign bus.waddr = waddr_reg;
    assign bus.wdata = wdata_reg;
    assign bus.grant = grant_reg;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a behavioural round-robin model.
module tb_wb_port_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Model state: next-priority requester and the expected output stage.
    int              m_ptr;
    logic            m_wen;
    logic [AW-1:0]   m_waddr;
    logic [DW-1:0]   m_wdata;
    logic [NREQ-1:0] m_grant;

    wb_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    wb_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_ptr   = 0;
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_grant = '0;
    endtask

    // Drives one cycle from a falling edge, samples ready before the rising edge,
    // advances the model over that edge and returns at the next falling edge.
    task automatic drive_cycle(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a,
                               input logic [NREQ*DW-1:0] d, input logic h, input logic f,
                               output logic [NREQ-1:0] obs_rdy, output logic [NREQ-1:0] exp_rdy);
        int sel;
        sel = -1;
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.hold      = h;
        bus.flush     = f;
        #1;
        obs_rdy = bus.req_ready;
        exp_rdy = '0;
        if (!h && !f) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (sel < 0 && v[idx]) sel = idx;
            end
        end
        if (sel >= 0) exp_rdy[sel] = 1'b1;
        @(posedge clk);
        if (f) begin
            m_wen = 1'b0;
        end else if (h) begin
            m_wen = m_wen;
        end else if (sel >= 0) begin
            m_waddr = a[sel*AW +: AW];
            m_wdata = d[sel*DW +: DW];
            m_wen   = (m_waddr != '0);
            m_grant = '0;
            m_grant[sel] = 1'b1;
            m_ptr   = (sel + 1) % NREQ;
        end else begin
            m_wen = 1'b0;
        end
        @(negedge clk);
        $display("txn t=%0t valid=%b hold=%b flush=%b ready=%b wen=%b waddr=%0d wdata=%h grant=%b",
                 $time, v, h, f, obs_rdy, bus.wen, bus.waddr, bus.wdata, bus.grant);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '1;
        bus.req_addr  = '1;
        bus.req_data  = '1;
        bus.hold      = 1'b0;
        bus.flush     = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", bus.req_ready); end
        checks++; if (bus.wen !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b exp=0", bus.wen); end
        checks++; if (bus.waddr !== '0 || bus.wdata !== '0) begin errors++; $display("FAIL reset_addr_data got=%0d/%h exp=0/0", bus.waddr, bus.wdata); end
        checks++; if (bus.grant !== 3'b000) begin errors++; $display("FAIL reset_grant got=%b exp=000", bus.grant); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic [NREQ-1:0] obs, exp;
        for (int n = 0; n < 2; n++) begin
            drive_cycle(3'b001, {10'd0, 5'd5}, {64'd0, 32'hDEAD_BEEF}, 1'b0, 1'b0, obs, exp);
            checks++; if (obs !== 3'b001 || obs !== exp) begin errors++; $display("FAIL single_ready got=%b exp=001", obs); end
            checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd5) begin errors++; $display("FAIL single_wen_addr got=%b/%0d exp=1/5", bus.wen, bus.waddr); end
            checks++; if (bus.wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_wdata got=%h exp=deadbeef", bus.wdata); end
            checks++; if (bus.grant !== 3'b001) begin errors++; $display("FAIL single_grant got=%b exp=001", bus.grant); end
        end
    endtask

    task automatic test_all_valid();
        logic [NREQ-1:0] obs, exp, want;
        apply_reset();
        for (int n = 0; n < 6; n++) begin
            drive_cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0, 1'b0, obs, exp);
            want = 3'b001 << (n % 3);
            checks++; if (obs !== want) begin errors++; $display("FAIL rr_ready n=%0d got=%b exp=%b", n, obs, want); end
            checks++; if (bus.grant !== want || bus.wen !== 1'b1) begin errors++; $display("FAIL rr_grant n=%0d got=%b/%b exp=%b/1", n, bus.grant, bus.wen, want); end
            checks++; if (bus.waddr !== AW'((n % 3) + 1)) begin errors++; $display("FAIL rr_waddr n=%0d got=%0d exp=%0d", n, bus.waddr, (n % 3) + 1); end
        end
    endtask

    task automatic test_x0();
        logic [NREQ-1:0] obs, exp;
        apply_reset();
        drive_cycle(3'b001, {5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'h9}, 1'b0, 1'b0, obs, exp);
        drive_cycle(3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h1234, 32'h0}, 1'b0, 1'b0, obs, exp);
        checks++; if (obs !== 3'b010) begin errors++; $display("FAIL x0_ready got=%b exp=010", obs); end
        checks++; if (bus.wen !== 1'b0) begin errors++; $display("FAIL x0_wen got=%b exp=0", bus.wen); end
        checks++; if (bus.grant !== 3'b010) begin errors++; $display("FAIL x0_grant got=%b exp=010", bus.grant); end
        drive_cycle(3'b111, {5'd4, 5'd4, 5'd4}, {32'h4, 32'h4, 32'h4}, 1'b0, 1'b0, obs, exp);
        checks++; if (obs !== 3'b100) begin errors++; $display("FAIL x0_next_ptr got=%b exp=100", obs); end
    endtask

    task automatic test_hold();
        logic [NREQ-1:0] obs, exp;
        apply_reset();
        drive_cycle(3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h55}, 1'b0, 1'b0, obs, exp);
        for (int n = 0; n < 3; n++) begin
            drive_cycle(3'b111, {5'd1, 5'd2, 5'd3}, {32'h1, 32'h2, 32'h3}, 1'b1, 1'b0, obs, exp);
            checks++; if (obs !== 3'b000) begin errors++; $display("FAIL hold_ready n=%0d got=%b exp=000", n, obs); end
            checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd7 || bus.wdata !== 32'h55) begin
                errors++; $display("FAIL hold_stage n=%0d got=%b/%0d/%h exp=1/7/55", n, bus.wen, bus.waddr, bus.wdata);
            end
        end
    endtask

    task automatic test_flush();
        logic [NREQ-1:0] obs, exp, want;
        int prior;
        drive_cycle(3'b111, {5'd1, 5'd2, 5'd3}, {32'h1, 32'h2, 32'h3}, 1'b0, 1'b0, obs, exp);
        prior = m_ptr;
        drive_cycle(3'b111, {5'd1, 5'd2, 5'd3}, {32'h1, 32'h2, 32'h3}, 1'b1, 1'b1, obs, exp);
        checks++; if (obs !== 3'b000) begin errors++; $display("FAIL flush_ready got=%b exp=000", obs); end
        checks++; if (bus.wen !== 1'b0) begin errors++; $display("FAIL flush_wen got=%b exp=0", bus.wen); end
        drive_cycle(3'b111, {5'd1, 5'd2, 5'd3}, {32'h1, 32'h2, 32'h3}, 1'b0, 1'b0, obs, exp);
        want = 3'b001 << prior;
        checks++; if (obs !== want) begin errors++; $display("FAIL flush_next got=%b exp=%b", obs, want); end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] obs, exp, v;
        logic [NREQ*AW-1:0] a;
        logic [NREQ*DW-1:0] d;
        logic h, f;
        for (int n = 0; n < 200; n++) begin
            v = NREQ'($urandom);
            a = {NREQ{5'($urandom)}} ^ (NREQ*AW)'($urandom);
            d = {$urandom, $urandom, $urandom};
            h = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 7) == 0);
            drive_cycle(v, a, d, h, f, obs, exp);
            checks++; if (obs !== exp) begin errors++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, obs, exp); end
            checks++; if (bus.wen !== m_wen || bus.grant !== m_grant) begin
                errors++; $display("FAIL rand_wen_grant n=%0d got=%b/%b exp=%b/%b", n, bus.wen, bus.grant, m_wen, m_grant);
            end
            checks++; if (bus.waddr !== m_waddr || bus.wdata !== m_wdata) begin
                errors++; $display("FAIL rand_addr_data n=%0d got=%0d/%h exp=%0d/%h", n, bus.waddr, bus.wdata, m_waddr, m_wdata);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [NREQ-1:0] obs, exp;
        drive_cycle(3'b111, {5'd6, 5'd6, 5'd6}, {32'h6, 32'h6, 32'h6}, 1'b0, 1'b0, obs, exp);
        drive_cycle(3'b111, {5'd6, 5'd6, 5'd6}, {32'h6, 32'h6, 32'h6}, 1'b0, 1'b0, obs, exp);
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.wen !== 1'b0 || bus.waddr !== '0 || bus.wdata !== '0) begin
            errors++; $display("FAIL async_stage got=%b/%0d/%h exp=0/0/0", bus.wen, bus.waddr, bus.wdata);
        end
        checks++; if (bus.grant !== 3'b000 || bus.req_ready !== 3'b000) begin
            errors++; $display("FAIL async_grant_ready got=%b/%b exp=000/000", bus.grant, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        drive_cycle(3'b111, {5'd6, 5'd6, 5'd6}, {32'h6, 32'h6, 32'h6}, 1'b0, 1'b0, obs, exp);
        checks++; if (obs !== 3'b001 || bus.grant !== 3'b001) begin
            errors++; $display("FAIL async_restart got=%b/%b exp=001/001", obs, bus.grant);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_valid();
        test_x0();
        test_hold();
        test_flush();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
